mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
Three-port arbiter that shares the single DDR3 memory controller request port (memaddr/memwr/memwdata/memreq/memack/memrdata) between three requesters: port 0 = video fetch, port 1 = CPU, port 2 = DMA.
- Grants one transaction at a time.
- Holds the granted command stable until the controller acks.
- Routes read data and a one-cycle ack back to the granted requester.
- Blocks all grants while the controller reports memreset.

Parameters:
AW, 20, address width (matches controller memaddr)
DW, 32, data width (matches controller memwdata/memrdata)
PRIO, 0, 0 = round-robin across ports 0..2; 1 = fixed priority, port 0 > 1 > 2

Ports:
clk  in  1  system clock, same clock as memory controller
reset  in  1  synchronous, active-high reset
memreset  in  1  controller still initialising; no grants while high
pNreq  in  1  (N=0..2) request from port N; held with command until pNack
pNwr  in  1  (N=0..2) 1 = write, 0 = read
pNaddr  in  AW  (N=0..2) word address
pNwdata  in  DW  (N=0..2) write data
pNack  out  1  (N=0..2) one-cycle completion pulse
pNrdata  out  DW  (N=0..2) read data, valid while pNack=1 (and held after)
memaddr  out  AW  to controller
memwr  out  1  to controller
memwdata  out  DW  to controller
memreq  out  1  to controller, one-cycle pulse
memack  in  1  from controller, one-cycle pulse
memrdata  in  DW  from controller, valid with memack
grant  out  2  index of the current/last granted port (debug)
busy  out  1  1 in ISSUE/WAIT/DONE

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=IDLE; memreq=0, memaddr=0, memwr=0, memwdata=0.
  - All pNack=0, pNrdata=0; grant=2 (so round-robin starts at port 0); busy=0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If memreset=0 and any pNreq=1, select port S (see selection below).
  - Register memaddr<=pSaddr, memwr<=pSwr, memwdata<=pSwdata, grant<=S, memreq<=1; go to ISSUE.
  - Otherwise stay in IDLE with memreq=0.
- ISSUE: memreq<=0 (pulse exactly one cycle); go to WAIT.
- WAIT:
  - memaddr/memwr/memwdata are held unchanged; the controller samples them after the request.
  - On memack=1: pGrdata<=memrdata (reads and writes alike), pGack<=1; go to DONE.
- DONE: pGack<=0; go to IDLE.
  - A requester clears or replaces its req/command on the edge where it samples pNack=1.
  - pNreq is sampled only in IDLE, so a completed request is never re-granted.
- Selection:
  - PRIO=0: search order grant+1, grant+2, grant (mod 3); first asserted pNreq wins.
  - PRIO=1: lowest-index asserted pNreq wins.
- Latency: pNreq sampled in IDLE at edge T → memreq=1 in cycle T+1 → memack at cycle M → pNack=1 in cycle M+1. The minimum gap between back-to-back grants is 1 IDLE cycle after DONE.
- Only the granted port's pNack/pNrdata change; other ports' pNrdata hold their values.
- Boundary conditions:
  - memack in IDLE, ISSUE or DONE: ignored, no ack is generated.
  - memreset rising during ISSUE/WAIT: the transaction continues to completion; only new grants are blocked.
  - Reset during ISSUE/WAIT/DONE: the transaction is abandoned, no pNack is issued, and a later memack is ignored.
  - pNreq dropping while granted (protocol violation): the transaction still completes and the ack is still pulsed.
  - No timeout: WAIT persists until memack.
- busy=1 in ISSUE, WAIT and DONE.

Test Plan:
1. Reset with memreset=1 and all pNreq=1 for 10 cycles → memreq never asserts. Drop memreset → memreq pulses 1 cycle later with port 0's command; grant=0.
2. p1 write only, addr=0x12345, wdata=0xDEADBEEF; controller model acks 12 cycles after memreq → memaddr/memwdata stable for all 12 cycles, p1ack one pulse 1 cycle after memack, p0ack/p2ack stay 0.
3. p2 read addr=0x00010; model returns memrdata=0xCAFEF00D → p2rdata=0xCAFEF00D while p2ack=1; p0rdata/p1rdata unchanged.
4. PRIO=0, all three reqs held high; each requester re-presents its request after every ack → grant sequence 0,1,2,0,1,2; no port receives two consecutive grants.
5. PRIO=1, same stimulus → grants always 0. Drop p0req → then 1,1,…
6. Assert reset during WAIT, then inject memack 3 cycles later → no pNack. The next request after reset issues normally with grant=0.

Source files
------------

// File: rtl/mem_arb.sv
// Three-port arbiter sharing one memory-controller request port between
// video fetch (port 0), CPU (port 1) and DMA (port 2).
module mem_arb #(
  parameter int unsigned AW   = 20,
  parameter int unsigned DW   = 32,
  parameter int unsigned PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memreset,
  input  logic          p0req,
  input  logic          p0wr,
  input  logic [AW-1:0] p0addr,
  input  logic [DW-1:0] p0wdata,
  output logic          p0ack,
  output logic [DW-1:0] p0rdata,
  input  logic          p1req,
  input  logic          p1wr,
  input  logic [AW-1:0] p1addr,
  input  logic [DW-1:0] p1wdata,
  output logic          p1ack,
  output logic [DW-1:0] p1rdata,
  input  logic          p2req,
  input  logic          p2wr,
  input  logic [AW-1:0] p2addr,
  input  logic [DW-1:0] p2wdata,
  output logic          p2ack,
  output logic [DW-1:0] p2rdata,
  output logic [AW-1:0] memaddr,
  output logic          memwr,
  output logic [DW-1:0] memwdata,
  output logic          memreq,
  input  logic          memack,
  input  logic [DW-1:0] memrdata,
  output logic [1:0]    grant,
  output logic          busy
);

  localparam int unsigned NP = 3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_memaddr, w_memaddr_nxt;
  logic          r_memwr, w_memwr_nxt;
  logic [DW-1:0] r_memwdata, w_memwdata_nxt;
  logic          r_memreq, w_memreq_nxt;
  logic [1:0]    r_grant, w_grant_nxt;
  logic          r_busy, w_busy_nxt;
  logic [NP-1:0] r_ack, w_ack_nxt;
  logic [DW-1:0] r_rdata [NP];
  logic [DW-1:0] w_rdata_nxt [NP];

  logic [NP-1:0] w_req, w_wr;
  logic [AW-1:0] w_addr [NP];
  logic [DW-1:0] w_wdata [NP];
  logic [1:0]    w_sel;

  assign w_req      = {p2req, p1req, p0req};
  assign w_wr       = {p2wr, p1wr, p0wr};
  assign w_addr[0]  = p0addr;
  assign w_addr[1]  = p1addr;
  assign w_addr[2]  = p2addr;
  assign w_wdata[0] = p0wdata;
  assign w_wdata[1] = p1wdata;
  assign w_wdata[2] = p2wdata;

  // Round-robin search starts one past the last grant; only meaningful when |req.
  function automatic logic [1:0] rr_pick(input logic [NP-1:0] req, input logic [1:0] last);
    logic [1:0] pick;
    pick = 2'd0;
    case (last)
      2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
    return pick;
  endfunction

  function automatic logic [1:0] fixed_pick(input logic [NP-1:0] req);
    return req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
  endfunction

  always_comb begin
    if (PRIO != 0) w_sel = fixed_pick(w_req);
    else           w_sel = rr_pick(w_req, r_grant);
  end

  // Next-state and next-output logic; every register holds unless updated.
  always_comb begin
    w_state_nxt    = r_state;
    w_memaddr_nxt  = r_memaddr;
    w_memwr_nxt    = r_memwr;
    w_memwdata_nxt = r_memwdata;
    w_memreq_nxt   = 1'b0;
    w_grant_nxt    = r_grant;
    w_ack_nxt      = '0;
    for (int i = 0; i < NP; i++) w_rdata_nxt[i] = r_rdata[i];

    case (r_state)
      S_IDLE: begin
        if (!memreset && (|w_req)) begin
          for (int i = 0; i < NP; i++) begin
            if (w_sel == 2'(i)) begin
              w_memaddr_nxt  = w_addr[i];
              w_memwr_nxt    = w_wr[i];
              w_memwdata_nxt = w_wdata[i];
            end
          end
          w_grant_nxt  = w_sel;
          w_memreq_nxt = 1'b1;
          w_state_nxt  = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (memack) begin
          for (int i = 0; i < NP; i++) begin
            if (r_grant == 2'(i)) begin
              w_rdata_nxt[i] = memrdata;
              w_ack_nxt[i]   = 1'b1;
            end
          end
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_memaddr  <= '0;
      r_memwr    <= 1'b0;
      r_memwdata <= '0;
      r_memreq   <= 1'b0;
      r_grant    <= 2'd2;
      r_busy     <= 1'b0;
      r_ack      <= '0;
      for (int i = 0; i < NP; i++) r_rdata[i] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_memaddr  <= w_memaddr_nxt;
      r_memwr    <= w_memwr_nxt;
      r_memwdata <= w_memwdata_nxt;
      r_memreq   <= w_memreq_nxt;
      r_grant    <= w_grant_nxt;
      r_busy     <= w_busy_nxt;
      r_ack      <= w_ack_nxt;
      for (int i = 0; i < NP; i++) r_rdata[i] <= w_rdata_nxt[i];
    end
  end

  assign memaddr  = r_memaddr;
  assign memwr    = r_memwr;
  assign memwdata = r_memwdata;
  assign memreq   = r_memreq;
  assign grant    = r_grant;
  assign busy     = r_busy;
  assign p0ack    = r_ack[0];
  assign p1ack    = r_ack[1];
  assign p2ack    = r_ack[2];
  assign p0rdata  = r_rdata[0];
  assign p1rdata  = r_rdata[1];
  assign p2rdata  = r_rdata[2];

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: reference arbitration model plus a memory
// controller model; a separate monitor pops expected acks and checks them.
module tb_mem_arb;
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;
  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- main DUT (round-robin) ----------------
  logic          reset, memreset;
  logic [2:0]    req, wr;
  logic [AW-1:0] addr [3];
  logic [DW-1:0] wdata [3];
  logic          ack0, ack1, ack2;
  logic [2:0]    ack_v;
  logic [DW-1:0] rdata [3];
  logic [AW-1:0] memaddr;
  logic          memwr, memreq, memack, busy;
  logic [DW-1:0] memwdata, memrdata;
  logic [1:0]    grant;

  assign ack_v = {ack2, ack1, ack0};

  mem_arb #(.AW(AW), .DW(DW), .PRIO(0)) u_dut (
    .clk(clk), .reset(reset), .memreset(memreset),
    .p0req(req[0]), .p0wr(wr[0]), .p0addr(addr[0]), .p0wdata(wdata[0]), .p0ack(ack0), .p0rdata(rdata[0]),
    .p1req(req[1]), .p1wr(wr[1]), .p1addr(addr[1]), .p1wdata(wdata[1]), .p1ack(ack1), .p1rdata(rdata[1]),
    .p2req(req[2]), .p2wr(wr[2]), .p2addr(addr[2]), .p2wdata(wdata[2]), .p2ack(ack2), .p2rdata(rdata[2]),
    .memaddr(memaddr), .memwr(memwr), .memwdata(memwdata), .memreq(memreq),
    .memack(memack), .memrdata(memrdata), .grant(grant), .busy(busy)
  );

  // ---------------- second DUT (fixed priority) ----------------
  logic          f_rst, f_memack;
  logic [2:0]    f_req;
  logic [AW-1:0] f_addr [3];
  logic [DW-1:0] f_wdata [3];
  logic          f_ack0, f_ack1, f_ack2;
  logic [2:0]    f_ack;
  logic [DW-1:0] f_rdata [3];
  logic [AW-1:0] f_memaddr;
  logic          f_memwr, f_memreq, f_busy;
  logic [DW-1:0] f_memwdata, f_memrdata;
  logic [1:0]    f_grant;

  assign f_ack = {f_ack2, f_ack1, f_ack0};

  mem_arb #(.AW(AW), .DW(DW), .PRIO(1)) u_fix (
    .clk(clk), .reset(f_rst), .memreset(1'b0),
    .p0req(f_req[0]), .p0wr(1'b0), .p0addr(f_addr[0]), .p0wdata(f_wdata[0]), .p0ack(f_ack0), .p0rdata(f_rdata[0]),
    .p1req(f_req[1]), .p1wr(1'b0), .p1addr(f_addr[1]), .p1wdata(f_wdata[1]), .p1ack(f_ack1), .p1rdata(f_rdata[1]),
    .p2req(f_req[2]), .p2wr(1'b0), .p2addr(f_addr[2]), .p2wdata(f_wdata[2]), .p2ack(f_ack2), .p2rdata(f_rdata[2]),
    .memaddr(f_memaddr), .memwr(f_memwr), .memwdata(f_memwdata), .memreq(f_memreq),
    .memack(f_memack), .memrdata(f_memrdata), .grant(f_grant), .busy(f_busy)
  );

  // ---------------- reference model state ----------------
  typedef struct {
    int            port;
    logic [DW-1:0] rd;
    int            cyc;
  } exp_t;
  exp_t sb[$];

  int            m_free = 0;      // first posedge at which a new grant may be sampled
  int            m_last = 2;      // last granted port
  bit            pending = 0;     // transaction outstanding at the controller model
  int            ack_at, issue_cyc, h_port, n_grants = 0;
  logic [AW-1:0] h_addr;
  logic          h_wr;
  logic [DW-1:0] h_wdata;
  int            mode = 0;        // 0 re-present, 1 single-shot, 2 random
  int            fix_delay = 0;
  bit            fix_rd_en = 0;
  logic [DW-1:0] fix_rd;
  bit            spur_en = 0, inj_ack = 0;
  int            grant_log[$];

  function automatic int ref_pick(input logic [2:0] r, input int last, input bit fixed);
    if (fixed) begin
      for (int i = 0; i < 3; i++) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= 3; k++) if (r[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  task automatic new_cmd(input int p);
    req[p]   = 1'b1;
    wr[p]    = 1'($urandom_range(1));
    addr[p]  = AW'($urandom);
    wdata[p] = $urandom;
  endtask

  // One cycle: check DUT against the model, run the controller, update requesters.
  task automatic step();
    bit exp_mr;
    int p;
    logic [DW-1:0] rd;
    @(negedge clk);
    if (reset) begin
      m_free  = cyc + 1;
      pending = 0;
      m_last  = 2;
    end
    exp_mr = !reset && !memreset && (cyc >= m_free) && (req != 3'b000);
    chk("memreq", memreq, exp_mr);
    if (exp_mr) begin
      p = ref_pick(req, m_last, 1'b0);
      m_last = p;
      grant_log.push_back(p);
      chk("grant", grant, p);
      chk("issue_addr", memaddr, addr[p]);
      chk("issue_wr", memwr, wr[p]);
      chk("issue_wdata", memwdata, wdata[p]);
      pending   = 1;
      h_port    = p;
      h_addr    = addr[p];
      h_wr      = wr[p];
      h_wdata   = wdata[p];
      issue_cyc = cyc;
      ack_at    = cyc + ((fix_delay != 0) ? fix_delay : int'($urandom_range(8, 1)));
      m_free    = BIG;
      n_grants++;
    end else if (pending) begin
      chk("hold_addr", memaddr, h_addr);
      chk("hold_wr", memwr, h_wr);
      chk("hold_wdata", memwdata, h_wdata);
    end
    chk("busy", busy, !reset && (cyc + 1 < m_free));

    memack = 1'b0;
    if (pending && cyc == ack_at) begin
      rd = fix_rd_en ? fix_rd : DW'($urandom);
      memack   = 1'b1;
      memrdata = rd;
      sb.push_back('{h_port, rd, cyc + 1});
      pending  = 0;
      m_free   = cyc + 3;
    end else if (inj_ack) begin
      memack   = 1'b1;
      memrdata = $urandom;
      inj_ack  = 0;
    end else if (spur_en && (!pending || cyc == issue_cyc) && $urandom_range(99) < 5) begin
      memack   = 1'b1;
      memrdata = $urandom;
    end

    for (int q = 0; q < 3; q++) begin
      if (ack_v[q]) begin
        if (mode == 0 || (mode == 2 && $urandom_range(99) < 50)) new_cmd(q);
        else req[q] = 1'b0;
      end else if (!req[q] && mode == 2 && $urandom_range(99) < 30) begin
        new_cmd(q);
      end
    end
    if (mode == 2 && pending && $urandom_range(99) < 2) req[h_port] = 1'b0;
    if (mode == 2 && $urandom_range(99) < 2) memreset = ~memreset;
  endtask

  task automatic drain(input int max);
    int c = 0;
    while ((pending || sb.size() != 0 || (cyc + 1 < m_free) || (req != 3'b000 && !memreset)) && c < max) begin
      step();
      c++;
    end
    chk("drain_timeout", 64'(c < max), 1);
  endtask

  // Monitor: pops an expected ack on its cycle; any other ack is unexpected.
  logic [DW-1:0] exp_rd [3];
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      for (int i = 0; i < 3; i++) exp_rd[i] = '0;
      sb.delete();
    end else if (sb.size() != 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("ack_port", ack_v, 3'b001 << e.port);
      exp_rd[e.port] = e.rd;
      for (int i = 0; i < 3; i++) chk($sformatf("rdata%0d", i), rdata[i], exp_rd[i]);
    end else if (ack_v != 3'b000) begin
      chk("unexpected_ack", ack_v, 0);
    end
  end

  task automatic fix_test();
    bit seen;
    int ep;
    f_rst = 1'b1; f_req = 3'b111; f_memack = 1'b0; f_memrdata = '0;
    for (int i = 0; i < 3; i++) begin f_addr[i] = AW'(i + 1); f_wdata[i] = DW'(i); end
    repeat (2) @(negedge clk);
    f_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ep = (i < 4) ? 0 : 1;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        if (f_memreq) seen = 1;
      end
      chk("fix_memreq_seen", 64'(seen), 1);
      chk("fix_grant", f_grant, ep);
      chk("fix_addr", f_memaddr, AW'(ep + 1));
      @(negedge clk);
      @(negedge clk);
      f_memack = 1'b1; f_memrdata = DW'(32'h100 + i);
      @(negedge clk);
      f_memack = 1'b0;
      chk("fix_ack", f_ack, 3'b001 << ep);
      chk("fix_rdata", f_rdata[ep], DW'(32'h100 + i));
      if (i == 3) f_req[0] = 1'b0;
    end
  endtask

  initial begin
    int c;
    reset = 1'b1; memreset = 1'b1; memack = 1'b0; memrdata = '0;
    f_rst = 1'b1; f_req = 3'b000; f_memack = 1'b0; f_memrdata = '0;
    for (int i = 0; i < 3; i++) begin f_addr[i] = '0; f_wdata[i] = '0; new_cmd(i); end

    // Reset + controller init with all ports requesting, then round-robin rotation.
    mode = 0;
    repeat (10) step();
    reset = 1'b0;
    repeat (3) step();
    memreset = 1'b0;
    c = 0;
    while (n_grants < 6 && c < 300) begin step(); c++; end
    chk("rr_grant_count", 64'(n_grants >= 6), 1);
    for (int i = 0; i < 6 && i < grant_log.size(); i++) chk("rr_order", grant_log[i], i % 3);
    mode = 1;
    drain(400);

    // Single CPU write with a slow controller.
    fix_delay = 12;
    req[1] = 1'b1; wr[1] = 1'b1; addr[1] = AW'(20'h12345); wdata[1] = 32'hDEADBEEF;
    drain(100);
    // DMA read returning a known word.
    fix_delay = 0; fix_rd_en = 1; fix_rd = 32'hCAFEF00D;
    req[2] = 1'b1; wr[2] = 1'b0; addr[2] = AW'(20'h00010); wdata[2] = '0;
    drain(100);
    fix_rd_en = 0;

    // Randomized traffic with memreset toggles, stray acks and dropped requests.
    mode = 2; spur_en = 1;
    repeat (3000) step();
    mode = 1; spur_en = 0; memreset = 1'b0;
    drain(400);

    // Reset in the middle of a transaction, then a stale controller ack.
    fix_delay = 20;
    req[0] = 1'b1; wr[0] = 1'b0; addr[0] = AW'(20'h00abc);
    c = 0;
    while (!pending && c < 20) begin step(); c++; end
    chk("abandon_issued", 64'(pending), 1);
    repeat (5) step();
    req = 3'b000;
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    inj_ack = 1;
    repeat (6) step();
    fix_delay = 0;
    grant_log.delete();
    new_cmd(0);
    drain(100);
    chk("post_reset_grants", grant_log.size(), 1);
    if (grant_log.size() != 0) chk("post_reset_grant", grant_log[0], 0);

    fix_test();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
